// File: rtl/tgroup_dispatcher_pkg.sv
// Shared compute-unit types for the thread-group dispatcher: default widths,
// scalar field types and the dispatcher FSM encoding.
package tgroup_dispatcher_pkg;

  localparam int unsigned PC_WIDTH        = 32;
  localparam int unsigned ADDR_WIDTH      = 32;
  localparam int unsigned TBLOCK_IDX_BITS = 4;
  localparam int unsigned TGROUP_ID_BITS  = 4;

  typedef logic [PC_WIDTH-1:0]        pc_t;
  typedef logic [ADDR_WIDTH-1:0]      addr_t;
  typedef logic [TBLOCK_IDX_BITS-1:0] tblock_idx_t;
  typedef logic [TBLOCK_IDX_BITS:0]   tblock_cnt_t;
  typedef logic [TGROUP_ID_BITS-1:0]  tgroup_id_t;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_DISPATCH = 1'b1
  } state_e;

endpackage

// File: rtl/tgroup_dispatcher_lzc.sv
// Lowest-set-bit finder: returns the index of the least significant 1 in vec,
// or 0 with empty raised when vec has no bits set.
module tgroup_dispatcher_lzc #(
  parameter int unsigned Width    = 16,
  parameter int unsigned CntWidth = (Width > 1) ? $clog2(Width) : 1
) (
  input  logic [Width-1:0]    vec,
  output logic [CntWidth-1:0] cnt,
  output logic                empty
);

  // NOTE: every always_comb output gets a default before the loop, so no path leaves it unassigned (no latch).
  always_comb begin
    cnt = '0;
    for (int i = Width - 1; i >= 0; i--) begin
      if (vec[i]) cnt = CntWidth'(i);
    end
    empty = ~|vec;
  end

endmodule

// File: rtl/tgroup_dispatcher.sv
// Splits thread-group launch jobs into one-per-cycle warp allocations and
// tracks per-group block completions, reporting each finished group once.
module tgroup_dispatcher
  import tgroup_dispatcher_pkg::*;
#(
  parameter int unsigned PcWidth       = PC_WIDTH,
  parameter int unsigned AddressWidth  = ADDR_WIDTH,
  parameter int unsigned TblockIdxBits = TBLOCK_IDX_BITS,
  parameter int unsigned TgroupIdBits  = TGROUP_ID_BITS
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     job_valid_i,
  output logic                     job_ready_o,
  input  logic [PcWidth-1:0]       job_pc_i,
  input  logic [AddressWidth-1:0]  job_dp_addr_i,
  input  logic [TblockIdxBits:0]   job_num_tblocks_i,
  input  logic [TgroupIdBits-1:0]  job_tgroup_id_i,
  input  logic                     warp_free_i,
  output logic                     allocate_warp_o,
  output logic [PcWidth-1:0]       allocate_pc_o,
  output logic [AddressWidth-1:0]  allocate_dp_addr_o,
  output logic [TblockIdxBits-1:0] allocate_tblock_idx_o,
  output logic [TgroupIdBits-1:0]  allocate_tgroup_id_o,
  input  logic                     tblock_done_i,
  input  logic [TgroupIdBits-1:0]  tblock_done_id_i,
  output logic                     tblock_done_ready_o,
  output logic                     tgroup_done_o,
  output logic [TgroupIdBits-1:0]  tgroup_done_id_o,
  input  logic                     tgroup_done_ready_i,
  output logic                     busy_o
);

  localparam int unsigned NumGroups = 2 ** TgroupIdBits;
  localparam int unsigned CntWidth  = TblockIdxBits + 1;

  state_e state, state_next;

  logic [PcWidth-1:0]       job_pc;
  logic [AddressWidth-1:0]  job_dp_addr;
  logic [CntWidth-1:0]      job_num;
  logic [TgroupIdBits-1:0]  job_id;
  logic [TblockIdxBits-1:0] idx;

  logic [CntWidth-1:0]      remain [NumGroups];
  logic [NumGroups-1:0]     remain_nz;
  logic [NumGroups-1:0]     pending;
  logic [NumGroups-1:0]     pending_set;
  logic [NumGroups-1:0]     pending_clr;

  logic                     accept;
  logic                     handshake;
  logic                     last_block;
  logic                     done_handshake;
  logic                     lzc_empty;
  logic [TgroupIdBits-1:0]  lowest_pending;

  assign accept         = job_valid_i && job_ready_o;
  assign handshake      = allocate_warp_o;
  assign last_block     = ({1'b0, idx} == (job_num - CntWidth'(1)));
  assign done_handshake = tgroup_done_o && tgroup_done_ready_i;

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:     if (accept && (job_num_tblocks_i != '0)) state_next = ST_DISPATCH;
      ST_DISPATCH: if (handshake && last_block)             state_next = ST_IDLE;
      default:                                              state_next = ST_IDLE;
    endcase
  end

  // A group id may be reused only once its blocks and its done report are both retired.
  always_comb begin
    job_ready_o     = (state == ST_IDLE) && (remain[job_tgroup_id_i] == '0)
                      && !pending[job_tgroup_id_i];
    allocate_warp_o = (state == ST_DISPATCH) && warp_free_i;
    busy_o          = (state == ST_DISPATCH) || (|remain_nz) || (|pending);
  end

  // ---------------------------------------------------------------------------
  // Latched job and block index
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      job_pc      <= '0;
      job_dp_addr <= '0;
      job_num     <= '0;
      job_id      <= '0;
      idx         <= '0;
    end else if (accept) begin
      job_pc      <= job_pc_i;
      job_dp_addr <= job_dp_addr_i;
      job_num     <= job_num_tblocks_i;
      job_id      <= job_tgroup_id_i;
      idx         <= '0;
    end else if (handshake && !last_block) begin
      idx <= idx + TblockIdxBits'(1);
    end
  end

  assign allocate_pc_o         = job_pc;
  assign allocate_dp_addr_o    = job_dp_addr;
  assign allocate_tblock_idx_o = idx;
  assign allocate_tgroup_id_o  = job_id;

  // ---------------------------------------------------------------------------
  // Per-group outstanding block counters and done-pending bits
  // ---------------------------------------------------------------------------
  always_comb begin
    pending_set = '0;
    pending_clr = '0;
    remain_nz   = '0;
    for (int g = 0; g < NumGroups; g++) begin
      remain_nz[g] = (remain[g] != '0);
      if (accept && (job_tgroup_id_i == TgroupIdBits'(g)) && (job_num_tblocks_i == '0))
        pending_set[g] = 1'b1;
      if (tblock_done_i && (tblock_done_id_i == TgroupIdBits'(g)) && (remain[g] == CntWidth'(1)))
        pending_set[g] = 1'b1;
      if (done_handshake && (lowest_pending == TgroupIdBits'(g)))
        pending_clr[g] = 1'b1;
    end
  end

  // NOTE: the counter array is reset like any other flop so busy_o and job_ready_o are defined out of reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int g = 0; g < NumGroups; g++) remain[g] <= '0;
      pending <= '0;
    end else begin
      for (int g = 0; g < NumGroups; g++) begin
        if (accept && (job_tgroup_id_i == TgroupIdBits'(g)))
          remain[g] <= job_num_tblocks_i;
        else if (tblock_done_i && (tblock_done_id_i == TgroupIdBits'(g)) && (remain[g] != '0))
          remain[g] <= remain[g] - CntWidth'(1);
      end
      pending <= (pending & ~pending_clr) | pending_set;
    end
  end

  tgroup_dispatcher_lzc #(
    .Width    (NumGroups),
    .CntWidth (TgroupIdBits)
  ) u_lzc (
    .vec   (pending),
    .cnt   (lowest_pending),
    .empty (lzc_empty)
  );

  assign tgroup_done_o       = !lzc_empty;
  assign tgroup_done_id_o    = lowest_pending;
  assign tblock_done_ready_o = 1'b1;

  // A completion for a group with nothing outstanding means the ITS lost track of a block.
  assert property (@(posedge clk_i) disable iff (rst_i)
                   tblock_done_i |-> (remain[tblock_done_id_i] != '0));

endmodule

// File: tb/tb_tgroup_dispatcher.sv
// Directed bench for tgroup_dispatcher: inputs change on the falling edge,
// outputs are compared 1ns later, state advances on the rising edge.
module tb_tgroup_dispatcher;
  import tgroup_dispatcher_pkg::*;

  logic        clk;
  logic        rst;
  logic        job_valid;
  logic        job_ready;
  pc_t         job_pc;
  addr_t       job_dp_addr;
  tblock_cnt_t job_num;
  tgroup_id_t  job_id;
  logic        warp_free;
  logic        alloc;
  pc_t         alloc_pc;
  addr_t       alloc_dp;
  tblock_idx_t alloc_idx;
  tgroup_id_t  alloc_id;
  logic        tblock_done;
  tgroup_id_t  tblock_done_id;
  logic        tblock_done_ready;
  logic        tgroup_done;
  tgroup_id_t  tgroup_done_id;
  logic        tgroup_done_ready;
  logic        busy;

  int checks = 0;
  int errors = 0;

  tgroup_dispatcher dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .job_valid_i           (job_valid),
    .job_ready_o           (job_ready),
    .job_pc_i              (job_pc),
    .job_dp_addr_i         (job_dp_addr),
    .job_num_tblocks_i     (job_num),
    .job_tgroup_id_i       (job_id),
    .warp_free_i           (warp_free),
    .allocate_warp_o       (alloc),
    .allocate_pc_o         (alloc_pc),
    .allocate_dp_addr_o    (alloc_dp),
    .allocate_tblock_idx_o (alloc_idx),
    .allocate_tgroup_id_o  (alloc_id),
    .tblock_done_i         (tblock_done),
    .tblock_done_id_i      (tblock_done_id),
    .tblock_done_ready_o   (tblock_done_ready),
    .tgroup_done_o         (tgroup_done),
    .tgroup_done_id_o      (tgroup_done_id),
    .tgroup_done_ready_i   (tgroup_done_ready),
    .busy_o                (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one full cycle, ending at the falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    job_valid = 1'b0; job_pc = '0; job_dp_addr = '0; job_num = '0; job_id = '0;
    warp_free = 1'b0; tblock_done = 1'b0; tblock_done_id = '0; tgroup_done_ready = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    check("rst_alloc",      alloc,             1'b0);
    check("rst_done",       tgroup_done,       1'b0);
    check("rst_done_id",    tgroup_done_id,    4'd0);
    check("rst_busy",       busy,              1'b0);
    check("rst_job_ready",  job_ready,         1'b1);
    check("rst_alloc_pc",   alloc_pc,          32'h0);
    check("rst_alloc_idx",  alloc_idx,         4'd0);
    check("rst_done_ready", tblock_done_ready, 1'b1);

    // Job id=3 num=4 with a warp always free: idx 0..3 on consecutive cycles
    rst = 1'b0;
    job_valid = 1'b1; job_pc = 32'h1000; job_dp_addr = 32'h2000; job_num = 5'd4; job_id = 4'd3;
    warp_free = 1'b1;
    #1;
    check("j3_ready", job_ready, 1'b1);
    check("j3_idle_alloc", alloc, 1'b0);
    cyc();
    job_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("j3_alloc_%0d", i), alloc, 1'b1);
      check($sformatf("j3_idx_%0d", i), alloc_idx, 64'(i));
      check($sformatf("j3_pc_%0d", i), alloc_pc, 32'h1000);
      check($sformatf("j3_dp_%0d", i), alloc_dp, 32'h2000);
      check($sformatf("j3_id_%0d", i), alloc_id, 4'd3);
      check($sformatf("j3_ready_%0d", i), job_ready, 1'b0);
      cyc();
    end
    #1;
    check("j3_back_idle", alloc, 1'b0);
    check("j3_id_busy", job_ready, 1'b0);
    check("j3_busy", busy, 1'b1);

    // Four completions of group 3, then the done report is held while ready is low
    for (int i = 0; i < 4; i++) begin
      tblock_done = 1'b1; tblock_done_id = 4'd3;
      #1;
      check($sformatf("c3_not_done_%0d", i), tgroup_done, 1'b0);
      cyc();
    end
    tblock_done = 1'b0;
    #1;
    check("c3_done", tgroup_done, 1'b1);
    check("c3_done_id", tgroup_done_id, 4'd3);
    for (int i = 0; i < 3; i++) begin
      cyc();
      #1;
      check($sformatf("c3_hold_%0d", i), tgroup_done, 1'b1);
      check($sformatf("c3_hold_id_%0d", i), tgroup_done_id, 4'd3);
    end
    tgroup_done_ready = 1'b1;
    cyc();
    tgroup_done_ready = 1'b0;
    #1;
    check("c3_cleared", tgroup_done, 1'b0);
    check("c3_idle_busy", busy, 1'b0);
    check("c3_id_free", job_ready, 1'b1);

    // warp_free 1,0,0,1 during a num=2 job
    job_valid = 1'b1; job_pc = 32'h3000; job_dp_addr = 32'h3100; job_num = 5'd2; job_id = 4'd6;
    warp_free = 1'b1;
    cyc();
    job_valid = 1'b0;
    #1;
    check("wf_c0_alloc", alloc, 1'b1);
    check("wf_c0_idx", alloc_idx, 4'd0);
    cyc();
    warp_free = 1'b0;
    #1;
    check("wf_c1_alloc", alloc, 1'b0);
    check("wf_c1_idx", alloc_idx, 4'd1);
    cyc();
    #1;
    check("wf_c2_alloc", alloc, 1'b0);
    cyc();
    warp_free = 1'b1;
    #1;
    check("wf_c3_alloc", alloc, 1'b1);
    check("wf_c3_idx", alloc_idx, 4'd1);
    check("wf_c3_id", alloc_id, 4'd6);
    cyc();
    #1;
    check("wf_idle_alloc", alloc, 1'b0);
    check("wf_id_busy", job_ready, 1'b0);
    tblock_done = 1'b1; tblock_done_id = 4'd6;
    cyc();
    cyc();
    tblock_done = 1'b0;
    #1;
    check("wf_done", tgroup_done, 1'b1);
    check("wf_done_id", tgroup_done_id, 4'd6);
    tgroup_done_ready = 1'b1;
    cyc();
    tgroup_done_ready = 1'b0;
    #1;
    check("wf_cleared", tgroup_done, 1'b0);

    // Zero-block job for group 5
    job_valid = 1'b1; job_num = 5'd0; job_id = 4'd5;
    #1;
    check("z5_ready", job_ready, 1'b1);
    cyc();
    #1;
    check("z5_no_alloc", alloc, 1'b0);
    check("z5_done", tgroup_done, 1'b1);
    check("z5_done_id", tgroup_done_id, 4'd5);
    check("z5_blocked", job_ready, 1'b0);
    check("z5_busy", busy, 1'b1);
    cyc();
    job_valid = 1'b0;
    #1;
    check("z5_hold_id", tgroup_done_id, 4'd5);
    tgroup_done_ready = 1'b1;
    cyc();
    tgroup_done_ready = 1'b0;
    #1;
    check("z5_cleared", tgroup_done, 1'b0);
    check("z5_free", job_ready, 1'b1);
    check("z5_idle_busy", busy, 1'b0);

    // Groups 2 and 1 become pending on the same edge; id 1 reported first
    job_valid = 1'b1; job_pc = 32'h4000; job_dp_addr = 32'h4100; job_num = 5'd1; job_id = 4'd2;
    cyc();
    job_valid = 1'b0;
    #1;
    check("g2_alloc", alloc, 1'b1);
    check("g2_alloc_id", alloc_id, 4'd2);
    cyc();
    job_valid = 1'b1; job_num = 5'd0; job_id = 4'd1;
    tblock_done = 1'b1; tblock_done_id = 4'd2;
    #1;
    check("g12_accept", job_ready, 1'b1);
    cyc();
    tblock_done = 1'b0;
    #1;
    check("g12_done", tgroup_done, 1'b1);
    check("g12_first_id", tgroup_done_id, 4'd1);
    check("g1_rejected", job_ready, 1'b0);
    cyc();
    #1;
    check("g12_hold_id", tgroup_done_id, 4'd1);
    check("g1_still_rejected", job_ready, 1'b0);
    job_valid = 1'b0;
    tgroup_done_ready = 1'b1;
    cyc();
    #1;
    check("g12_second", tgroup_done, 1'b1);
    check("g12_second_id", tgroup_done_id, 4'd2);
    check("g1_free", job_ready, 1'b1);
    cyc();
    tgroup_done_ready = 1'b0;
    #1;
    check("g12_cleared", tgroup_done, 1'b0);
    check("g12_idle_busy", busy, 1'b0);

    // Reset asserted mid-dispatch at idx=2
    job_valid = 1'b1; job_pc = 32'h5000; job_dp_addr = 32'h5100; job_num = 5'd4; job_id = 4'd7;
    warp_free = 1'b1;
    cyc();
    job_valid = 1'b0;
    cyc();
    cyc();
    #1;
    check("mr_alloc", alloc, 1'b1);
    check("mr_idx", alloc_idx, 4'd2);
    rst = 1'b1;
    #1;
    check("mr_rst_alloc", alloc, 1'b0);
    check("mr_rst_ready", job_ready, 1'b1);
    check("mr_rst_busy", busy, 1'b0);
    check("mr_rst_idx", alloc_idx, 4'd0);
    check("mr_rst_pc", alloc_pc, 32'h0);
    cyc();
    rst = 1'b0;
    #1;
    check("mr_post_alloc", alloc, 1'b0);
    check("mr_post_ready", job_ready, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
